// File: rtl/fpall_pkg.sv
// Shared FP datapath package: format enum, lane geometry and alignment shifter helpers.
// Used by the align shifter pipe and its per-lane sub-shifter.
package fpall_pkg;

  typedef enum logic [1:0] {
    FP32     = 2'b00,
    FP16X2   = 2'b01,
    BF16X2   = 2'b10,
    FMT_RSVD = 2'b11
  } fp_fmt_e;

  localparam int FRAC_W      = 28;
  localparam int LANE_W      = 12;
  localparam int HI_LANE_MSB = 27;
  localparam int HI_STK      = 16;
  localparam int LO_LANE_MSB = 11;
  localparam int LO_STK      = 0;
  localparam int SAT32_DEF   = 27;
  localparam int SAT16_DEF   = 11;

  // Clamp a raw shift amount to the lane saturation point.
  function automatic logic [7:0] sat_shamt(logic [7:0] sh, int sat);
    return (sh > 8'(sat)) ? 8'(sat) : sh;
  endfunction

  // Right shift of the full FP32 lane; every bit pushed past bit 0 lands in the sticky bit.
  function automatic logic [27:0] rshift_sticky28(logic [27:0] x, logic [4:0] s);
    logic [27:0] shifted;
    logic [27:0] lost_mask;
    shifted   = x >> s;
    lost_mask = ~(28'hFFF_FFFF << s);
    return {shifted[27:1], shifted[0] | (|(x & lost_mask))};
  endfunction

endpackage

// File: rtl/align_shifter_pipe_if.sv
// Beat-level handshake bundle between exponent compare, the align shifter and the fraction adder.
interface align_shifter_pipe_if;

  logic                    in_valid_i;
  logic                    in_ready_o;
  fpall_pkg::fp_fmt_e      fmt_i;
  logic [27:0]             frac_i;
  logic [7:0]              shamt_h_i;
  logic [7:0]              shamt_l_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  fpall_pkg::fp_fmt_e      fmt_o;
  logic [27:0]             frac_o;

  modport slave (
    input  in_valid_i, fmt_i, frac_i, shamt_h_i, shamt_l_i, out_ready_i,
    output in_ready_o, out_valid_o, fmt_o, frac_o
  );

  modport master (
    output in_valid_i, fmt_i, frac_i, shamt_h_i, shamt_l_i, out_ready_i,
    input  in_ready_o, out_valid_o, fmt_o, frac_o
  );

endinterface

// File: rtl/rshift_sticky12.sv
// Combinational 12-bit lane right shifter with saturation; shifted-out bits OR into bit 0.
module rshift_sticky12
  import fpall_pkg::*;
#(
  parameter int SAT = SAT16_DEF
) (
  input  logic [7:0]  shamt,
  input  logic [11:0] din,
  output logic [11:0] dout
);

  logic [3:0]  s;
  logic [11:0] shifted;
  logic [11:0] lost_mask;

  always_comb begin
    s         = (shamt > 8'(SAT)) ? 4'(SAT) : shamt[3:0];
    shifted   = din >> s;
    lost_mask = ~(12'hFFF << s);
    dout      = {shifted[11:1], shifted[0] | (|(din & lost_mask))};
  end

endmodule

// File: rtl/align_shifter_pipe.sv
// Two-stage elastic pre-add alignment shifter: coarse shift in stage 1, fine shift in stage 2,
// with sticky carried in each lane's bit 0 so the two partial shifts compose exactly.
module align_shifter_pipe
  import fpall_pkg::*;
#(
  parameter int SAT32 = SAT32_DEF,
  parameter int SAT16 = SAT16_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  align_shifter_pipe_if.slave  bus
);

  logic        s1_valid, s2_valid;
  logic        s1_en, s2_en, accept;
  fp_fmt_e     s1_fmt, s2_fmt;
  logic [27:0] s1_frac, s2_frac, s1_frac_d, s2_frac_d;
  logic [27:0] fp32_coarse, fp32_fine;
  logic [2:0]  s1_fine_h, s1_fine_l, fine_h_d;
  logic [4:0]  s32;
  logic [3:0]  sh16, sl16;
  logic [11:0] hi_coarse, lo_coarse, hi_fine, lo_fine;

  assign s2_en          = ~s2_valid | bus.out_ready_i;
  assign s1_en          = ~s1_valid | s2_en;
  assign bus.in_ready_o = s1_en & ~flush_i;
  assign accept         = bus.in_valid_i & bus.in_ready_o;

  // Stage 1: saturate, apply the 16/8 (FP32) or 8 (per lane) coarse step, keep the 4/2/1 remainder.
  always_comb begin
    s32         = 5'(sat_shamt(bus.shamt_h_i, SAT32));
    sh16        = 4'(sat_shamt(bus.shamt_h_i, SAT16));
    sl16        = 4'(sat_shamt(bus.shamt_l_i, SAT16));
    fp32_coarse = rshift_sticky28(bus.frac_i, {s32[4:3], 3'b000});
    if (bus.fmt_i == FP32) begin
      s1_frac_d = fp32_coarse;
      fine_h_d  = s32[2:0];
    end else begin
      s1_frac_d = {hi_coarse, 4'b0000, lo_coarse};
      fine_h_d  = sh16[2:0];
    end
  end

  rshift_sticky12 #(.SAT(SAT16)) u_hi_coarse (
    .shamt ({4'b0000, sh16[3], 3'b000}),
    .din   (bus.frac_i[HI_LANE_MSB:HI_STK]),
    .dout  (hi_coarse)
  );

  rshift_sticky12 #(.SAT(SAT16)) u_lo_coarse (
    .shamt ({4'b0000, sl16[3], 3'b000}),
    .din   (bus.frac_i[LO_LANE_MSB:LO_STK]),
    .dout  (lo_coarse)
  );

  // Stage 2: fine shift of whatever stage 1 left; the gap nibble is forced to zero in dual mode.
  always_comb begin
    fp32_fine = rshift_sticky28(s1_frac, {2'b00, s1_fine_h});
    if (s1_fmt == FP32) s2_frac_d = fp32_fine;
    else                s2_frac_d = {hi_fine, 4'b0000, lo_fine};
  end

  rshift_sticky12 #(.SAT(SAT16)) u_hi_fine (
    .shamt ({5'b00000, s1_fine_h}),
    .din   (s1_frac[HI_LANE_MSB:HI_STK]),
    .dout  (hi_fine)
  );

  rshift_sticky12 #(.SAT(SAT16)) u_lo_fine (
    .shamt ({5'b00000, s1_fine_l}),
    .din   (s1_frac[LO_LANE_MSB:LO_STK]),
    .dout  (lo_fine)
  );

  // Valid bits: flush empties both stages; a stage drains when its successor takes the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_en) s1_valid <= accept;
      if (s2_en) s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_fmt    <= FP32;
      s1_frac   <= '0;
      s1_fine_h <= '0;
      s1_fine_l <= '0;
      s2_fmt    <= FP32;
      s2_frac   <= '0;
    end else begin
      if (accept) begin
        s1_fmt    <= bus.fmt_i;
        s1_frac   <= s1_frac_d;
        s1_fine_h <= fine_h_d;
        s1_fine_l <= sl16[2:0];
      end
      if (s2_en && s1_valid) begin
        s2_fmt  <= s1_fmt;
        s2_frac <= s2_frac_d;
      end
    end
  end

  assign bus.out_valid_o = s2_valid;
  assign bus.fmt_o       = s2_fmt;
  assign bus.frac_o      = s2_frac;

endmodule

// File: tb/tb_align_shifter_pipe.sv
// Self-checking bench for align_shifter_pipe: directed vectors, backpressure, reset/flush, random traffic.
module tb_align_shifter_pipe;
  import fpall_pkg::*;

  typedef struct packed {
    fp_fmt_e     fmt;
    logic [27:0] frac;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;

  align_shifter_pipe_if bus ();

  align_shifter_pipe dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: move each set bit down by s within a w-bit field; bits falling below 0 become sticky.
  function automatic logic [27:0] field_shift(logic [27:0] x, int w, int s);
    logic [27:0] r;
    logic st;
    r  = '0;
    st = 1'b0;
    for (int i = 0; i < w; i++)
      if (x[i]) begin
        if (i >= s) r[i - s] = 1'b1;
        else        st = 1'b1;
      end
    r[0] = r[0] | st;
    return r;
  endfunction

  function automatic logic [27:0] model(fp_fmt_e f, logic [27:0] x, logic [7:0] sh, logic [7:0] sl);
    int s_h, s_l;
    logic [27:0] hi, lo;
    if (f == FP32) begin
      s_h = (int'(sh) > 27) ? 27 : int'(sh);
      return field_shift(x, 28, s_h);
    end
    s_h = (int'(sh) > 11) ? 11 : int'(sh);
    s_l = (int'(sl) > 11) ? 11 : int'(sl);
    hi  = field_shift({16'b0, x[27:16]}, 12, s_h);
    lo  = field_shift({16'b0, x[11:0]}, 12, s_l);
    return {hi[11:0], 4'b0000, lo[11:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Scoreboard sampled mid-cycle: queue model results on accept, compare on output handshake.
  always @(negedge clk) begin
    beat_t e, nb;
    if (!rst_n) exp_q.delete();
    else begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) checkOutput("spurious_out_valid", 32'(bus.out_valid_o), 32'd0);
        else begin
          e = exp_q.pop_front();
          checkOutput("sb_frac", 32'(bus.frac_o), 32'(e.frac));
          checkOutput("sb_fmt", 32'(bus.fmt_o), 32'(e.fmt));
          n_out++;
        end
      end
      if (flush) exp_q.delete();
      else if (bus.in_valid_i && bus.in_ready_o) begin
        nb.fmt  = bus.fmt_i;
        nb.frac = model(bus.fmt_i, bus.frac_i, bus.shamt_h_i, bus.shamt_l_i);
        exp_q.push_back(nb);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input fp_fmt_e f, input logic [27:0] x,
                               input logic [7:0] sh, input logic [7:0] sl);
    bus.in_valid_i = v;
    bus.fmt_i      = f;
    bus.frac_i     = x;
    bus.shamt_h_i  = sh;
    bus.shamt_l_i  = sl;
    #1;
  endtask

  task automatic sendBeat(input fp_fmt_e f, input logic [27:0] x, input logic [7:0] sh, input logic [7:0] sl);
    logic acc;
    acc = 1'b0;
    applyStimulus(1'b1, f, x, sh, sl);
    for (int c = 0; c < 50 && !acc; c++) begin
      acc = bus.in_ready_o;
      tick();
    end
    checkOutput("send_accepted", 32'(acc), 32'd1);
    applyStimulus(1'b0, FP32, '0, '0, '0);
  endtask

  task automatic runDirected(input string tag, input fp_fmt_e f, input logic [27:0] x,
                             input logic [7:0] sh, input logic [7:0] sl, input logic [27:0] expv);
    sendBeat(f, x, sh, sl);
    for (int c = 0; c < 10 && !bus.out_valid_o; c++) tick();
    checkOutput({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
    checkOutput(tag, 32'(bus.frac_o), 32'(expv));
    tick();
  endtask

  task automatic drain();
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 200 && (exp_q.size() != 0 || bus.out_valid_o); c++) tick();
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic seen;
    int base;
    logic [7:0] sh, sl;
    bus.out_ready_i = 1'b1;
    applyStimulus(1'b0, FP32, '0, '0, '0);
    checkOutput("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("rst_frac", 32'(bus.frac_o), 32'd0);
    checkOutput("rst_fmt", 32'(bus.fmt_o), 32'(FP32));
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready_o), 32'd1);

    $display("[TB] latency and directed vectors");
    applyStimulus(1'b1, FP32, 28'h800_0000, 8'd4, 8'd0);
    tick();
    applyStimulus(1'b0, FP32, '0, '0, '0);
    checkOutput("lat_cycle1", 32'(bus.out_valid_o), 32'd0);
    tick();
    checkOutput("lat_cycle2", 32'(bus.out_valid_o), 32'd1);
    checkOutput("lat_frac", 32'(bus.frac_o), 32'h080_0000);
    tick();

    runDirected("fp32_sticky",   FP32,   28'h000_0038, 8'd4,   8'd99, 28'h000_0003);
    runDirected("fp32_sat200",   FP32,   28'h000_0038, 8'd200, 8'd0,  28'h000_0001);
    runDirected("fp32_sh27",     FP32,   28'h800_0000, 8'd27,  8'd0,  28'h000_0001);
    runDirected("fp32_sh26",     FP32,   28'h800_0000, 8'd26,  8'd0,  28'h000_0002);
    runDirected("fp32_sh0",      FP32,   28'h5A5_A5A5, 8'd0,   8'd7,  28'h5A5_A5A5);
    runDirected("dual_mixed",    FP16X2, 28'h800_00F8, 8'd3,   8'd20, 28'h100_0001);
    runDirected("dual_gap_only", BF16X2, 28'h000_F000, 8'd5,   8'd5,  28'h000_0000);
    runDirected("dual_sat_edge", FP16X2, 28'h800_0800, 8'd11,  8'd10, 28'h001_0002);
    runDirected("dual_sh0",      FMT_RSVD, 28'hABC_DEF1, 8'd0, 8'd0,  28'hABC_0EF1);

    $display("[TB] backpressure");
    base = n_out;
    bus.out_ready_i = 1'b0;
    sendBeat(FP32, 28'(32'($urandom)), 8'd3, 8'd0);
    sendBeat(FP16X2, 28'(32'($urandom)), 8'd9, 8'd2);
    applyStimulus(1'b1, FP32, 28'h123_4567, 8'd13, 8'd0);
    checkOutput("bp_ready_drop", 32'(bus.in_ready_o), 32'd0);
    tick(); tick(); tick();
    checkOutput("bp_ready_held", 32'(bus.in_ready_o), 32'd0);
    bus.out_ready_i = 1'b1;
    sendBeat(FP32, 28'h123_4567, 8'd13, 8'd0);
    sendBeat(BF16X2, 28'hFED_CBA9, 8'd1, 8'd6);
    drain();
    checkOutput("bp_out_count", 32'(n_out - base), 32'd4);

    $display("[TB] reset with beats in flight");
    bus.out_ready_i = 1'b0;
    sendBeat(FP32, 28'hFFF_FFFF, 8'd5, 8'd0);
    sendBeat(FP32, 28'h0F0_F0F0, 8'd1, 8'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("rst_mid_frac", 32'(bus.frac_o), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen |= bus.out_valid_o;
      tick();
    end
    checkOutput("rst_no_stale", 32'(seen), 32'd0);

    $display("[TB] flush with beats in flight");
    bus.out_ready_i = 1'b0;
    sendBeat(FP16X2, 28'hAAA_0555, 8'd2, 8'd3);
    sendBeat(FP32, 28'h333_3333, 8'd7, 8'd0);
    applyStimulus(1'b1, FP32, 28'h777_7777, 8'd1, 8'd0);
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready", 32'(bus.in_ready_o), 32'd0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, FP32, '0, '0, '0);
    checkOutput("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
    bus.out_ready_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen |= bus.out_valid_o;
      tick();
    end
    checkOutput("flush_no_stale", 32'(seen), 32'd0);

    $display("[TB] random traffic");
    base = n_out;
    for (int c = 0; c < 600; c++) begin
      sh = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(12, 255)) : 8'($urandom_range(0, 30));
      sl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(12, 255)) : 8'($urandom_range(0, 13));
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 3) != 0, fp_fmt_e'(2'($urandom_range(0, 3))),
                    28'(32'($urandom)), sh, sl);
      tick();
    end
    applyStimulus(1'b0, FP32, '0, '0, '0);
    drain();
    checkOutput("rand_some_output", 32'(n_out - base > 100), 32'd1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
